// File: rtl/cordic_uart_pkg.sv
// ---------------------------------------------------------------------------
// cordic_uart_pkg
// Shared constants for the CORDIC/UART command sequencer:
//   - FSM state encodings (plain localparams for legacy tool compatibility)
//   - command/response byte counts and the response byte order
//   - helper functions for the response byte mux and the overrun window
// ---------------------------------------------------------------------------
package cordic_uart_pkg;

    // Command is a 16-bit angle (MSB first); response is cos then sin, MSB first.
    localparam int BYTES_IN  = 2;
    localparam int BYTES_OUT = 4;
    localparam int IDX_W     = $clog2(BYTES_OUT);

    // FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GET_LO    = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_TX_LOAD   = 3'd4;
    localparam logic [2:0] ST_TX_ARM    = 3'd5;
    localparam logic [2:0] ST_TX_WAIT   = 3'd6;

    // Response byte order on the UART
    localparam logic [IDX_W-1:0] IDX_COS_HI = 2'd0;
    localparam logic [IDX_W-1:0] IDX_COS_LO = 2'd1;
    localparam logic [IDX_W-1:0] IDX_SIN_HI = 2'd2;
    localparam logic [IDX_W-1:0] IDX_SIN_LO = 2'd3;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_SIN_LO;

    // Select the response byte to transmit for a given index.
    function automatic logic [7:0] tx_byte_sel(
        input logic [15:0]      cos_v,
        input logic [15:0]      sin_v,
        input logic [IDX_W-1:0] idx
    );
        logic [7:0] b;
        case (idx)
            IDX_COS_HI: b = cos_v[15:8];
            IDX_COS_LO: b = cos_v[7:0];
            IDX_SIN_HI: b = sin_v[15:8];
            IDX_SIN_LO: b = sin_v[7:0];
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

    // True in the states where a received byte cannot be accepted.
    function automatic logic in_overrun_window(input logic [2:0] st);
        logic w;
        case (st)
            ST_START, ST_WAIT_DONE, ST_TX_LOAD, ST_TX_ARM, ST_TX_WAIT: w = 1'b1;
            default:                                                  w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cordic_uart_sequencer.sv
// ---------------------------------------------------------------------------
// cordic_uart_sequencer
// Command sequencer between a UART receiver/transmitter pair and a CORDIC core.
// Collects a 2-byte angle (high byte first) from RX, issues one CORDIC start,
// waits for completion (with a cycle timeout), then streams cos/sin back to TX
// as 4 bytes: cos[15:8], cos[7:0], sin[15:8], sin[7:0].
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset, wins over every event
//   i_rx_data/valid  received byte and its 1-cycle strobe
//   o_cordic_angle   angle to CORDIC, held from START until the next capture
//   o_cordic_start   1-cycle start pulse, one per command
//   i_cordic_done    1-cycle completion strobe (ignored outside WAIT_DONE)
//   i_cordic_cos/sin results, valid with i_cordic_done
//   o_tx_data        byte to transmitter, held until the next load
//   o_tx_start       1-cycle transmit request
//   i_tx_busy        transmitter busy, rises the cycle after o_tx_start
//   o_busy           high in every state except IDLE
//   o_err_timeout    1-cycle pulse when CORDIC fails to complete in time
//   o_err_overrun    1-cycle pulse when a byte arrives while a command runs
//
// All outputs are registered: the next-state/next-output logic is computed
// combinationally and captured in a single register stage.
// ---------------------------------------------------------------------------
module cordic_uart_sequencer
    import cordic_uart_pkg::*;
#(
    parameter int DATA_W  = 16,   // must be 16: the angle/results are exactly 2 bytes
    parameter int TIMEOUT = 1024  // WAIT_DONE cycles before abort
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [DATA_W-1:0] o_cordic_angle,
    output logic              o_cordic_start,
    input  logic              i_cordic_done,
    input  logic [DATA_W-1:0] i_cordic_cos,
    input  logic [DATA_W-1:0] i_cordic_sin,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    output logic              o_busy,
    output logic              o_err_timeout,
    output logic              o_err_overrun
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Registered state and outputs
    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_angle;
    logic              r_cordic_start;
    logic [DATA_W-1:0] r_cos;
    logic [DATA_W-1:0] r_sin;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_busy;
    logic              r_err_timeout;
    logic              r_err_overrun;

    // Next-state values
    logic [2:0]        w_state_nxt;
    logic [DATA_W-1:0] w_angle_nxt;
    logic              w_cordic_start_nxt;
    logic [DATA_W-1:0] w_cos_nxt;
    logic [DATA_W-1:0] w_sin_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic              w_tx_start_nxt;
    logic              w_err_timeout_nxt;
    logic              w_err_overrun_nxt;

    // Next-state and next-output decode for the command FSM
    always_comb begin
        w_state_nxt        = r_state;
        w_angle_nxt        = r_angle;
        w_cordic_start_nxt = 1'b0;
        w_cos_nxt          = r_cos;
        w_sin_nxt          = r_sin;
        w_idx_nxt          = r_idx;
        w_cnt_nxt          = r_cnt;
        w_tx_data_nxt      = r_tx_data;
        w_tx_start_nxt     = 1'b0;
        w_err_timeout_nxt  = 1'b0;

        // A byte arriving mid-command is dropped; the FSM below never sees it.
        if (i_rx_valid && in_overrun_window(r_state)) begin
            w_err_overrun_nxt = 1'b1;
        end else begin
            w_err_overrun_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    w_angle_nxt[15:8] = i_rx_data;
                    w_state_nxt       = ST_GET_LO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_GET_LO: begin
                // No inter-byte timeout: wait here indefinitely for the low byte.
                if (i_rx_valid) begin
                    w_angle_nxt[7:0]   = i_rx_data;
                    // Start is registered so it is high exactly while in START.
                    w_cordic_start_nxt = 1'b1;
                    w_state_nxt        = ST_START;
                end else begin
                    w_state_nxt = ST_GET_LO;
                end
            end

            ST_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                // Completion is checked first so done on the limit cycle still wins.
                if (i_cordic_done) begin
                    w_cos_nxt   = i_cordic_cos;
                    w_sin_nxt   = i_cordic_sin;
                    w_idx_nxt   = IDX_COS_HI;
                    w_state_nxt = ST_TX_LOAD;
                end else if (r_cnt == CNT_LIMIT) begin
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            ST_TX_LOAD: begin
                if (!i_tx_busy) begin
                    w_tx_data_nxt  = tx_byte_sel(r_cos, r_sin, r_idx);
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = ST_TX_ARM;
                end else begin
                    w_state_nxt = ST_TX_LOAD;
                end
            end

            ST_TX_ARM: begin
                // Dead cycle: the transmitter has not yet raised busy for this byte.
                w_state_nxt = ST_TX_WAIT;
            end

            ST_TX_WAIT: begin
                if (!i_tx_busy) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = ST_TX_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_TX_WAIT;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_angle        <= '0;
            r_cordic_start <= 1'b0;
            r_cos          <= '0;
            r_sin          <= '0;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_tx_data      <= 8'h00;
            r_tx_start     <= 1'b0;
            r_busy         <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_angle        <= w_angle_nxt;
            r_cordic_start <= w_cordic_start_nxt;
            r_cos          <= w_cos_nxt;
            r_sin          <= w_sin_nxt;
            r_idx          <= w_idx_nxt;
            r_cnt          <= w_cnt_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_tx_start     <= w_tx_start_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_err_timeout  <= w_err_timeout_nxt;
            r_err_overrun  <= w_err_overrun_nxt;
        end
    end

    assign o_cordic_angle = r_angle;
    assign o_cordic_start = r_cordic_start;
    assign o_tx_data      = r_tx_data;
    assign o_tx_start     = r_tx_start;
    assign o_busy         = r_busy;
    assign o_err_timeout  = r_err_timeout;
    assign o_err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_cordic_uart_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cordic_uart_sequencer
// Directed bench for the CORDIC/UART sequencer. A small transmitter model
// holds tx_busy for tx_len cycles after each tx_start; a negedge monitor
// records transmitted bytes and counts pulses. Expected values are written
// out by hand in each test task.
// ---------------------------------------------------------------------------
module tb_cordic_uart_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] cordic_angle;
    logic        cordic_start;
    logic        cordic_done;
    logic [15:0] cordic_cos;
    logic [15:0] cordic_sin;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cordic_uart_sequencer #(.DATA_W(16), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_cordic_angle(cordic_angle), .o_cordic_start(cordic_start),
        .i_cordic_done(cordic_done), .i_cordic_cos(cordic_cos), .i_cordic_sin(cordic_sin),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy),
        .o_busy(busy), .o_err_timeout(err_timeout), .o_err_overrun(err_overrun)
    );

    // Transmitter model: busy rises the cycle after tx_start, lasts tx_len cycles.
    int tx_len   = 4;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= tx_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Monitor, sampled on the falling edge
    logic [7:0] tx_q[$];
    int n_txs = 0, n_cs = 0, n_eto = 0, n_eov = 0, n_viol = 0;
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            tx_q.push_back(tx_data);
            n_txs++;
            if (tx_busy) n_viol++;
        end
        if (cordic_start === 1'b1) n_cs++;
        if (err_timeout === 1'b1)  n_eto++;
        if (err_overrun === 1'b1)  n_eov++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] c, input logic [15:0] s);
        cordic_cos  = c;
        cordic_sin  = s;
        cordic_done = 1'b1;
        tick();
        cordic_done = 1'b0;
        cordic_cos  = 16'h0000;
        cordic_sin  = 16'h0000;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data     = 8'($urandom);
            rx_valid    = 1'($urandom);
            cordic_done = 1'($urandom);
            cordic_cos  = 16'($urandom);
            cordic_sin  = 16'($urandom);
            tick();
        end
        vectors++; if (cordic_angle !== 16'h0000) begin miscompares++; $display("FAIL reset_angle: got %h expected 0000", cordic_angle); end
        vectors++; if (cordic_start !== 1'b0) begin miscompares++; $display("FAIL reset_cstart: got %b expected 0", cordic_start); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err_to: got %b expected 0", err_timeout); end
        vectors++; if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_err_ov: got %b expected 0", err_overrun); end
        rx_valid = 1'b0; cordic_done = 1'b0; cordic_cos = 16'h0000; cordic_sin = 16'h0000;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b[4] = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        int base = tx_q.size();
        int cs0  = n_cs;
        bit ok;
        tx_len = 5;
        send_byte(8'h40);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_getlo: got %b expected 1", busy); end
        vectors++; if (cordic_start !== 1'b0) begin miscompares++; $display("FAIL basic_no_early_start: got %b expected 0", cordic_start); end
        send_byte(8'h00);
        vectors++; if (cordic_start !== 1'b1) begin miscompares++; $display("FAIL basic_start_latency: got %b expected 1", cordic_start); end
        vectors++; if (cordic_angle !== 16'h4000) begin miscompares++; $display("FAIL basic_angle: got %h expected 4000", cordic_angle); end
        tick();
        vectors++; if (cordic_start !== 1'b0) begin miscompares++; $display("FAIL basic_start_width: got %b expected 0", cordic_start); end
        tick();
        pulse_done(16'h1234, 16'hABCD);
        wait_idle(500, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_idle_timeout: got busy %b expected 0 within budget", busy); end
        vectors++; if (tx_q.size() !== base + 4) begin miscompares++; $display("FAIL basic_tx_count: got %0d expected %0d", tx_q.size() - base, 4); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            vectors++; if (got !== exp_b[i]) begin miscompares++; $display("FAIL basic_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        vectors++; if (n_cs - cs0 !== 1) begin miscompares++; $display("FAIL basic_one_start: got %0d expected 1", n_cs - cs0); end
        vectors++; if (cordic_angle !== 16'h4000) begin miscompares++; $display("FAIL basic_angle_held: got %h expected 4000", cordic_angle); end
    endtask

    task automatic test_tx_flow();
        logic [7:0] exp_b[4] = '{8'h5A, 8'h5A, 8'hA5, 8'hA5};
        int base = tx_q.size();
        int n0   = n_txs;
        bit ok;
        tx_len = 160;
        send_byte(8'h12);
        send_byte(8'h34);
        tick();
        pulse_done(16'h5A5A, 16'hA5A5);
        wait_idle(1200, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL txflow_idle_timeout: got busy %b expected 0 within budget", busy); end
        vectors++; if (n_txs - n0 !== 4) begin miscompares++; $display("FAIL txflow_start_count: got %0d expected 4", n_txs - n0); end
        vectors++; if (n_viol !== 0) begin miscompares++; $display("FAIL txflow_start_while_busy: got %0d expected 0", n_viol); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            vectors++; if (got !== exp_b[i]) begin miscompares++; $display("FAIL txflow_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        // Let the transmitter finish the last frame before the next test.
        repeat (170) tick();
        tx_len = 5;
    endtask

    task automatic test_timeout();
        logic [7:0] exp_b[4] = '{8'h11, 8'h11, 8'h22, 8'h22};
        int n0   = n_txs;
        int eto0 = n_eto;
        int base;
        bit ok;
        send_byte(8'h01);
        send_byte(8'h02);
        vectors++; if (cordic_start !== 1'b1) begin miscompares++; $display("FAIL to_start: got %b expected 1", cordic_start); end
        repeat (16) tick();
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_not_early: got %b expected 0", err_timeout); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL to_busy_before: got %b expected 1", busy); end
        tick();
        vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_pulse: got %b expected 1", err_timeout); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_idle: got %b expected 0", busy); end
        tick();
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_pulse_width: got %b expected 0", err_timeout); end
        vectors++; if (n_txs !== n0) begin miscompares++; $display("FAIL to_no_tx: got %0d expected %0d", n_txs, n0); end
        // Done arriving on the same cycle as the limit must win.
        base = tx_q.size();
        send_byte(8'h03);
        send_byte(8'h04);
        repeat (16) tick();
        pulse_done(16'h1111, 16'h2222);
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_done_wins_err: got %b expected 0", err_timeout); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL to_done_wins_busy: got %b expected 1", busy); end
        wait_idle(500, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL to_idle_timeout: got busy %b expected 0 within budget", busy); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            vectors++; if (got !== exp_b[i]) begin miscompares++; $display("FAIL to_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        vectors++; if (n_eto - eto0 !== 1) begin miscompares++; $display("FAIL to_err_count: got %0d expected 1", n_eto - eto0); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_a[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] exp_b[4] = '{8'hCA, 8'hFE, 8'hBE, 8'hEF};
        int base = tx_q.size();
        bit ok;
        repeat (10) tick();
        send_byte(8'h20);
        send_byte(8'h00);
        tick();
        send_byte(8'h55);
        vectors++; if (err_overrun !== 1'b1) begin miscompares++; $display("FAIL ov_pulse: got %b expected 1", err_overrun); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ov_busy: got %b expected 1", busy); end
        vectors++; if (cordic_angle !== 16'h2000) begin miscompares++; $display("FAIL ov_angle: got %h expected 2000", cordic_angle); end
        tick();
        vectors++; if (err_overrun !== 1'b0) begin miscompares++; $display("FAIL ov_pulse_width: got %b expected 0", err_overrun); end
        pulse_done(16'h0102, 16'h0304);
        wait_idle(500, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ov_idle_timeout: got busy %b expected 0 within budget", busy); end
        vectors++; if (tx_q.size() !== base + 4) begin miscompares++; $display("FAIL ov_tx_count: got %0d expected 4", tx_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            vectors++; if (got !== exp_a[i]) begin miscompares++; $display("FAIL ov_byte%0d: got %h expected %h", i, got, exp_a[i]); end
        end
        base = tx_q.size();
        repeat (10) tick();
        send_byte(8'h7F);
        send_byte(8'hFF);
        vectors++; if (cordic_angle !== 16'h7FFF) begin miscompares++; $display("FAIL ov_next_angle: got %h expected 7fff", cordic_angle); end
        tick();
        pulse_done(16'hCAFE, 16'hBEEF);
        wait_idle(500, ok);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            vectors++; if (got !== exp_b[i]) begin miscompares++; $display("FAIL ov_next_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] exp_b[4] = '{8'h0F, 8'h0F, 8'hF0, 8'hF0};
        int base = tx_q.size();
        int n0   = n_txs;
        int i_wait;
        bit ok;
        tx_len = 20;
        repeat (10) tick();
        send_byte(8'h11);
        send_byte(8'h22);
        tick();
        pulse_done(16'hDEAD, 16'hBEEF);
        for (i_wait = 0; i_wait < 300; i_wait++) begin
            if (n_txs >= n0 + 2) break;
            tick();
        end
        vectors++; if (n_txs !== n0 + 2) begin miscompares++; $display("FAIL rst_tx_two_bytes: got %0d expected 2", n_txs - n0); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_tx_busy: got %b expected 0", busy); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        vectors++; if (cordic_angle !== 16'h0000) begin miscompares++; $display("FAIL rst_tx_angle: got %h expected 0000", cordic_angle); end
        // A stray done in IDLE must be ignored.
        pulse_done(16'h9999, 16'h8888);
        repeat (100) tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_stray_done_busy: got %b expected 0", busy); end
        vectors++; if (n_txs !== n0 + 2) begin miscompares++; $display("FAIL rst_no_more_tx: got %0d expected 2", n_txs - n0); end
        vectors++; if (tx_q[base] !== 8'hDE || tx_q[base + 1] !== 8'hAD) begin miscompares++; $display("FAIL rst_partial_bytes: got %h %h expected de ad", tx_q[base], tx_q[base + 1]); end
        base = tx_q.size();
        send_byte(8'h33);
        send_byte(8'h44);
        vectors++; if (cordic_angle !== 16'h3344) begin miscompares++; $display("FAIL rst_new_angle: got %h expected 3344", cordic_angle); end
        tick();
        pulse_done(16'h0F0F, 16'hF0F0);
        wait_idle(600, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rst_new_idle_timeout: got busy %b expected 0 within budget", busy); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            vectors++; if (got !== exp_b[i]) begin miscompares++; $display("FAIL rst_new_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        cordic_done = 1'b0;
        cordic_cos  = 16'h0000;
        cordic_sin  = 16'h0000;
        test_reset();
        test_basic();
        test_tx_flow();
        test_timeout();
        test_overrun();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
